// File: rtl/exe_stage_md.sv
// Execute stage: registered output, single-cycle ALU, and an iterative unsigned
// multiply/divide unit (one bit per cycle) that owns the HI/LO registers.
module exe_stage_md #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [ALUOP_W-1:0] i_aluOp,
  input  logic [2:0]         i_mdOp,
  input  logic [XLEN-1:0]    i_srcA,
  input  logic [XLEN-1:0]    i_srcB,
  input  logic [XLEN-1:0]    i_rd2,
  input  logic [RA_W-1:0]    i_WRA,
  input  logic               i_regWe,
  input  logic               i_dmemWe,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_result,
  output logic [XLEN-1:0]    o_rd2,
  output logic [RA_W-1:0]    o_WRA,
  output logic               o_regWe,
  output logic               o_dmemWe,
  output logic               o_busy
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  // wh/wl: working product halves (MUL) or remainder/quotient (DIV)
  logic [XLEN-1:0]   wh_q, wh_d, wl_q, wl_d, opb_q, opb_d;
  logic [XLEN-1:0]   prd2_q, prd2_d;
  logic [RA_W-1:0]   pwra_q, pwra_d;
  logic              preg_q, preg_d, pdm_q, pdm_d;
  logic              vld_q, vld_d;
  logic [XLEN-1:0]   res_q, res_d, rd2_q, rd2_d;
  logic [RA_W-1:0]   wra_q, wra_d;
  logic              regwe_q, regwe_d, dmwe_q, dmwe_d;

  logic is_mul, is_div, is_mfhi, is_mflo, accept;
  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [CNT_W-1:0]  cnt_inc;

  assign is_mul  = (i_mdOp == 3'd1);
  assign is_div  = (i_mdOp == 3'd2);
  assign is_mfhi = (i_mdOp == 3'd3);
  assign is_mflo = (i_mdOp == 3'd4);
  assign o_ready = (state_q == S_IDLE) & (~vld_q | i_ready);
  assign accept  = i_valid & o_ready & ~i_flush;
  assign shamt   = i_srcB[SH_W-1:0];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    alu_res = '0;
    case (i_aluOp)
      ALUOP_W'(0): alu_res = i_srcA + i_srcB;
      ALUOP_W'(1): alu_res = i_srcA - i_srcB;
      ALUOP_W'(2): alu_res = i_srcA & i_srcB;
      ALUOP_W'(3): alu_res = i_srcA | i_srcB;
      ALUOP_W'(4): alu_res = i_srcA ^ i_srcB;
      ALUOP_W'(5): alu_res = {{(XLEN-1){1'b0}}, ($signed(i_srcA) < $signed(i_srcB))};
      ALUOP_W'(6): alu_res = {{(XLEN-1){1'b0}}, (i_srcA < i_srcB)};
      ALUOP_W'(7): alu_res = i_srcA << shamt;
      ALUOP_W'(8): alu_res = i_srcA >> shamt;
      ALUOP_W'(9): alu_res = $unsigned($signed(i_srcA) >>> shamt);
      default:     alu_res = '0;
    endcase
  end

  // Shift-add multiply step and restoring divide step on the shared working regs
  assign mul_sum  = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {wh_q, wl_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    opb_d    = opb_q;
    prd2_d   = prd2_q;
    pwra_d   = pwra_q;
    preg_d   = preg_q;
    pdm_d    = pdm_q;
    vld_d    = vld_q;
    res_d    = res_q;
    rd2_d    = rd2_q;
    wra_d    = wra_q;
    regwe_d  = regwe_q;
    dmwe_d   = dmwe_q;
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && (is_mul || is_div)) begin
            state_d = is_mul ? S_MUL : S_DIV;
            cnt_d   = '0;
            wh_d    = '0;
            wl_d    = i_srcA;
            opb_d   = i_srcB;
            prd2_d  = i_rd2;
            pwra_d  = i_WRA;
            preg_d  = i_regWe;
            pdm_d   = i_dmemWe;
            vld_d   = 1'b0;
          end else if (accept) begin
            vld_d   = 1'b1;
            res_d   = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
            rd2_d   = i_rd2;
            wra_d   = i_WRA;
            regwe_d = i_regWe;
            dmwe_d  = i_dmemWe;
          end else if (i_ready) begin
            vld_d   = 1'b0;
          end
        end
        S_MUL: begin
          wh_d  = mul_sum[XLEN:1];
          wl_d  = {mul_sum[0], wl_q[XLEN-1:1]};
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_END) state_d = S_DONE;
        end
        S_DIV: begin
          if (opb_q == '0) begin
            wh_d    = wl_q;
            wl_d    = '1;
            state_d = S_DONE;
          end else begin
            wh_d  = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
            wl_d  = {wl_q[XLEN-2:0], ~div_diff[XLEN]};
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_END) state_d = S_DONE;
          end
        end
        S_DONE: begin
          hi_d    = wh_q;
          lo_d    = wl_q;
          vld_d   = 1'b1;
          res_d   = wl_q;
          rd2_d   = prd2_q;
          wra_d   = pwra_q;
          regwe_d = preg_q;
          dmwe_d  = pdm_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      opb_q   <= '0;
      prd2_q  <= '0;
      pwra_q  <= '0;
      preg_q  <= 1'b0;
      pdm_q   <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      rd2_q   <= '0;
      wra_q   <= '0;
      regwe_q <= 1'b0;
      dmwe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      opb_q   <= opb_d;
      prd2_q  <= prd2_d;
      pwra_q  <= pwra_d;
      preg_q  <= preg_d;
      pdm_q   <= pdm_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      rd2_q   <= rd2_d;
      wra_q   <= wra_d;
      regwe_q <= regwe_d;
      dmwe_q  <= dmwe_d;
    end
  end

  assign o_valid  = vld_q;
  assign o_result = res_q;
  assign o_rd2    = rd2_q;
  assign o_WRA    = wra_q;
  assign o_regWe  = regwe_q;
  assign o_dmemWe = dmwe_q;
  assign o_busy   = (state_q == S_MUL) || (state_q == S_DIV);

endmodule

// File: tb/tb_exe_stage_md.sv
// Bench for exe_stage_md: transaction-level model checked every cycle, plus
// directed literal expectations and a randomized phase.
module tb_exe_stage_md;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int ALUOP_W = 5;

  logic            clk = 1'b0, rstn = 1'b0;
  logic            i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic [4:0]      i_aluOp = '0;
  logic [2:0]      i_mdOp = '0;
  logic [31:0]     i_srcA = '0, i_srcB = '0, i_rd2 = '0;
  logic [4:0]      i_WRA = '0;
  logic            i_regWe = 1'b0, i_dmemWe = 1'b0;
  logic            o_ready, o_valid, o_regWe, o_dmemWe, o_busy;
  logic [31:0]     o_result, o_rd2;
  logic [4:0]      o_WRA;

  always #5 clk = ~clk;

  exe_stage_md #(.XLEN(XLEN), .RA_W(RA_W), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_aluOp(i_aluOp), .i_mdOp(i_mdOp), .i_srcA(i_srcA), .i_srcB(i_srcB), .i_rd2(i_rd2),
    .i_WRA(i_WRA), .i_regWe(i_regWe), .i_dmemWe(i_dmemWe), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_rd2(o_rd2), .o_WRA(o_WRA),
    .o_regWe(o_regWe), .o_dmemWe(o_dmemWe), .o_busy(o_busy)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no response within bound, expected one", nm);
  endtask

  // Transaction-level model: registered outputs, HI/LO, and edges left until a MUL/DIV result
  logic        m_vld, m_regwe, m_dmwe, p_regwe, p_dmwe, exp_rdy;
  logic [31:0] m_res, m_rd2, m_hi, m_lo, p_hi, p_lo, p_rd2;
  logic [4:0]  m_wra, p_wra;
  logic [63:0] prod;
  int          m_left;

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd6: return (a < b) ? 32'd1 : 32'd0;
      5'd7: return a << b[4:0];
      5'd8: return a >> b[4:0];
      5'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_vld = 0; m_res = 0; m_rd2 = 0; m_wra = 0; m_regwe = 0; m_dmwe = 0;
        m_hi = 0; m_lo = 0; m_left = 0;
      end
      exp_rdy = (m_left == 0) && (!m_vld || i_ready);
      chk("o_valid", {31'd0, o_valid}, {31'd0, m_vld});
      chk("o_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
      chk("o_busy", {31'd0, o_busy}, (m_left > 1) ? 32'd1 : 32'd0);
      if (m_vld) begin
        chk("o_result", o_result, m_res);
        chk("o_rd2", o_rd2, m_rd2);
        chk("o_WRA", {27'd0, o_WRA}, {27'd0, m_wra});
        chk("o_regWe", {31'd0, o_regWe}, {31'd0, m_regwe});
        chk("o_dmemWe", {31'd0, o_dmemWe}, {31'd0, m_dmwe});
      end
      if (rstn) begin
        if (i_flush) begin
          m_vld = 0; m_left = 0;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_vld = 1; m_res = p_lo;
            m_rd2 = p_rd2; m_wra = p_wra; m_regwe = p_regwe; m_dmwe = p_dmwe;
          end
        end else if (i_valid && exp_rdy) begin
          if (i_mdOp == 3'd1 || i_mdOp == 3'd2) begin
            if (i_mdOp == 3'd1) begin
              prod = 64'(i_srcA) * 64'(i_srcB);
              p_hi = prod[63:32]; p_lo = prod[31:0]; m_left = XLEN + 1;
            end else if (i_srcB == 0) begin
              p_hi = i_srcA; p_lo = 32'hFFFF_FFFF; m_left = 2;
            end else begin
              p_hi = i_srcA % i_srcB; p_lo = i_srcA / i_srcB; m_left = XLEN + 1;
            end
            p_rd2 = i_rd2; p_wra = i_WRA; p_regwe = i_regWe; p_dmwe = i_dmemWe;
            m_vld = 0;
          end else begin
            m_vld = 1;
            m_res = (i_mdOp == 3'd3) ? m_hi : (i_mdOp == 3'd4) ? m_lo : ref_alu(i_aluOp, i_srcA, i_srcB);
            m_rd2 = i_rd2; m_wra = i_WRA; m_regwe = i_regWe; m_dmwe = i_dmemWe;
          end
        end else if (i_ready) begin
          m_vld = 0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] md, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    i_valid = v; i_mdOp = md; i_aluOp = op; i_srcA = a; i_srcB = b;
    i_rd2 = $urandom; i_WRA = 5'($urandom); i_regWe = 1'($urandom); i_dmemWe = 1'($urandom);
  endtask

  task automatic issue(input logic [2:0] md, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input string nm);
    bit done = 0;
    @(posedge clk); #1;
    drive(1'b1, md, op, a, b);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (o_ready && !i_flush) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    i_valid = 1'b0;
    if (!done) tmo(nm);
  endtask

  task automatic expect_out(input logic [31:0] exp, input string nm);
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_valid) begin
        chk(nm, o_result, exp);
        done = 1;
      end
    end
    if (!done) tmo(nm);
  endtask

  task automatic expect_md(input logic [31:0] exp, input int exp_busy, input string nm);
    bit done = 0;
    int nb = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_busy) nb++;
      if (o_valid) begin
        chk(nm, o_result, exp);
        done = 1;
      end
    end
    if (!done) tmo(nm);
    else chk({nm, "_busy_cycles"}, nb, exp_busy);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] md;
    drive(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;

    issue(3'd0, 5'd0, 32'd5, 32'd7, "add");                  expect_out(32'd12, "add_5_7");
    issue(3'd0, 5'd9, 32'h8000_0000, 32'd4, "sra");         expect_out(32'hF800_0000, "sra");
    issue(3'd0, 5'd5, 32'hFFFF_FFFF, 32'd1, "slt");         expect_out(32'd1, "slt");
    issue(3'd0, 5'd6, 32'hFFFF_FFFF, 32'd1, "sltu");        expect_out(32'd0, "sltu");

    // Backpressure: ADD held for 3 cycles while SUB waits upstream
    repeat (2) @(posedge clk);
    #1; i_ready = 1'b0;
    issue(3'd0, 5'd0, 32'd1, 32'd2, "add_bp");
    drive(1'b1, 3'd0, 5'd1, 32'd0, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_result", o_result, 32'd3);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
    end
    @(posedge clk); #1; i_ready = 1'b1;
    @(negedge clk); chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1; i_valid = 1'b0;
    @(negedge clk); chk("sub_0_1", o_result, 32'hFFFF_FFFF);

    issue(3'd1, 5'd0, 32'hFFFF_FFFF, 32'd2, "multu");       expect_md(32'hFFFF_FFFE, 32, "multu_lo");
    issue(3'd3, 5'd0, 32'd0, 32'd0, "mfhi");                expect_out(32'd1, "mfhi_mul");
    issue(3'd4, 5'd0, 32'd0, 32'd0, "mflo");                expect_out(32'hFFFF_FFFE, "mflo_mul");
    issue(3'd2, 5'd0, 32'd100, 32'd7, "divu");              expect_md(32'd14, 32, "divu_lo");
    issue(3'd3, 5'd0, 32'd0, 32'd0, "mfhi");                expect_out(32'd2, "divu_hi");
    issue(3'd2, 5'd0, 32'd9, 32'd0, "div0");                expect_md(32'hFFFF_FFFF, 1, "div0_lo");
    issue(3'd3, 5'd0, 32'd0, 32'd0, "mfhi");                expect_out(32'd9, "div0_hi");

    // Flush during the 10th DIV cycle: no result, HI/LO untouched
    issue(3'd2, 5'd0, 32'd1000, 32'd3, "div_fl");
    repeat (9) @(posedge clk);
    #1; i_flush = 1'b1;
    @(posedge clk); #1; i_flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_busy", {31'd0, o_busy}, 32'd0);
    chk("fl_ready", {31'd0, o_ready}, 32'd1);
    issue(3'd3, 5'd0, 32'd0, 32'd0, "mfhi");                expect_out(32'd9, "fl_hi");
    issue(3'd4, 5'd0, 32'd0, 32'd0, "mflo");                expect_out(32'hFFFF_FFFF, "fl_lo");

    // Async reset in the middle of a multiply
    issue(3'd1, 5'd0, 32'd7, 32'd9, "mul_rst");
    repeat (5) @(posedge clk);
    #1; rstn = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, o_busy}, 32'd0);
    chk("mrst_valid", {31'd0, o_valid}, 32'd0);
    chk("mrst_result", o_result, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    issue(3'd3, 5'd0, 32'd0, 32'd0, "mfhi");                expect_out(32'd0, "mrst_hi");
    issue(3'd4, 5'd0, 32'd0, 32'd0, "mflo");                expect_out(32'd0, "mrst_lo");

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 15))
        10: md = 3'd1;
        11: md = 3'd2;
        12: md = 3'd3;
        13: md = 3'd4;
        14: md = 3'($urandom_range(5, 7));
        default: md = 3'd0;
      endcase
      drive(1'($urandom_range(0, 4) < 3), md, 5'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 39) == 0);
      if (c == 2000) rstn = 1'b0;
      if (c == 2003) rstn = 1'b1;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
